// File: rtl/spi_master_sequencer.sv
// SPI mode-0 master byte sequencer: CS setup/hold spacing, divided S_CLK,
// MSB-first shift out on MOSI and shift in from MISO, with byte bursts.
module spi_master_sequencer #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       START,
    input  logic       LAST,
    input  logic [7:0] TX_DATA,
    input  logic       ABORT,
    output logic       READY,
    output logic       BUSY,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    output logic       DONE,
    output logic       S_CLK,
    output logic       MOSI,
    input  logic       MISO,
    output logic       CS
);

    localparam int M1   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int MAXC = (M1 > CS_HOLD) ? M1 : CS_HOLD;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] DIV_END   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] SETUP_END = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] HOLD_END  = CW'(CS_HOLD - 1);

    typedef enum logic [2:0] {
        IDLE, SETUP, LOW_PH, HIGH_PH, GAP, HOLD
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    tx;
    logic [7:0]    rx;
    logic          last_q;
    logic [7:0]    rx_next;

    // MISO is captured once, in the first cycle of each high phase
    always_comb begin
        rx_next = rx;
        if (cnt == '0)
            rx_next = {rx[6:0], MISO};
    end

    always_ff @(posedge CLK) begin
        RX_VALID <= 1'b0;
        DONE     <= 1'b0;
        if (CLR) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            tx      <= '0;
            rx      <= '0;
            last_q  <= 1'b0;
            CS      <= 1'b1;
            S_CLK   <= 1'b0;
            MOSI    <= 1'b0;
            READY   <= 1'b1;
            BUSY    <= 1'b0;
            RX_DATA <= '0;
        end else if (ABORT) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            CS      <= 1'b1;
            S_CLK   <= 1'b0;
            MOSI    <= 1'b0;
            READY   <= 1'b1;
            BUSY    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (START) begin
                        tx     <= TX_DATA;
                        last_q <= LAST;
                        MOSI   <= TX_DATA[7];
                        cnt    <= '0;
                        CS     <= 1'b0;
                        BUSY   <= 1'b1;
                        READY  <= 1'b0;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == SETUP_END) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        state   <= LOW_PH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LOW_PH: begin
                    if (cnt == DIV_END) begin
                        cnt   <= '0;
                        S_CLK <= 1'b1;
                        state <= HIGH_PH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HIGH_PH: begin
                    rx <= rx_next;
                    if (cnt == DIV_END) begin
                        cnt   <= '0;
                        S_CLK <= 1'b0;
                        if (bit_cnt != 3'd7) begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx      <= {tx[6:0], tx[7]};
                            MOSI    <= tx[6];
                            state   <= LOW_PH;
                        end else begin
                            RX_DATA  <= rx_next;
                            RX_VALID <= 1'b1;
                            if (last_q) begin
                                state <= HOLD;
                            end else begin
                                READY <= 1'b1;
                                state <= GAP;
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    // burst continuation skips the CS setup spacing
                    if (START) begin
                        tx      <= TX_DATA;
                        last_q  <= LAST;
                        MOSI    <= TX_DATA[7];
                        cnt     <= '0;
                        bit_cnt <= '0;
                        READY   <= 1'b0;
                        state   <= LOW_PH;
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_END) begin
                        cnt   <= '0;
                        CS    <= 1'b1;
                        BUSY  <= 1'b0;
                        READY <= 1'b1;
                        MOSI  <= 1'b0;
                        DONE  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_sequencer.sv
// Bench for spi_master_sequencer: behavioural SPI slave plus cycle-timing
// monitor; default-parameter and fastest-parameter instances.
module tb_spi_master_sequencer;

    localparam int DIV = 4;
    localparam int SU  = 2;
    localparam int HO  = 2;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       clr, start, last, abort;
    logic [7:0] tx_data;
    logic       ready, busy, rx_valid, done, sclk, mosi, miso, cs;
    logic [7:0] rx_data;

    logic       start_b, last_b, abort_b, miso_b;
    logic [7:0] tx_b;
    logic       ready_b, busy_b, rx_valid_b, done_b, sclk_b, mosi_b, cs_b;
    logic [7:0] rx_data_b;

    spi_master_sequencer #(.CLK_DIV(DIV), .CS_SETUP(SU), .CS_HOLD(HO)) dut (
        .CLK(clk), .CLR(clr), .START(start), .LAST(last), .TX_DATA(tx_data),
        .ABORT(abort), .READY(ready), .BUSY(busy), .RX_DATA(rx_data),
        .RX_VALID(rx_valid), .DONE(done), .S_CLK(sclk), .MOSI(mosi),
        .MISO(miso), .CS(cs)
    );

    spi_master_sequencer #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1)) dut_fast (
        .CLK(clk), .CLR(clr), .START(start_b), .LAST(last_b), .TX_DATA(tx_b),
        .ABORT(abort_b), .READY(ready_b), .BUSY(busy_b), .RX_DATA(rx_data_b),
        .RX_VALID(rx_valid_b), .DONE(done_b), .S_CLK(sclk_b), .MOSI(mosi_b),
        .MISO(miso_b), .CS(cs_b)
    );

    // SPI slave: presents slave_byte MSB first, advancing on S_CLK fall
    logic       loop_en = 1'b1;
    logic [7:0] slave_byte = 8'h00;
    logic [2:0] sidx = 3'd0;
    always @(negedge cs) sidx = 3'd0;
    always @(negedge sclk) if (!cs) sidx = sidx + 3'd1;
    assign miso = loop_en ? mosi : slave_byte[~sidx];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int rises, hi_len, lo_len, bad_hi, bad_lo, viol;
    int rxv_cnt, done_cnt, cs_falls, cs_rises, cs_fall_cyc, rxv_cyc, done_cyc;
    int mbits;
    logic fall_pend;
    logic prev_s = 1'b0, prev_cs = 1'b1;
    logic [7:0] mcap;
    logic [7:0] mosi_q [$];
    logic [7:0] rx_q [$];
    int rise_q [$];

    always @(negedge clk) begin
        if (sclk && !prev_s) begin
            rises++;
            rise_q.push_back(cyc);
            if (fall_pend && lo_len != DIV) bad_lo++;
            hi_len = 0;
            mcap = {mcap[6:0], mosi};
            mbits++;
            if (mbits == 8) begin
                mosi_q.push_back(mcap);
                mbits = 0;
            end
        end
        if (sclk) hi_len++;
        if (!sclk && prev_s) begin
            if (hi_len != DIV) bad_hi++;
            fall_pend = 1'b1;
            lo_len = 0;
        end
        if (!sclk && fall_pend) lo_len++;
        if (rx_valid) begin
            rxv_cnt++;
            rxv_cyc = cyc;
            rx_q.push_back(rx_data);
            fall_pend = 1'b0;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (!cs && prev_cs) begin
            cs_falls++;
            cs_fall_cyc = cyc;
        end
        if (cs && !prev_cs) cs_rises++;
        if (sclk && cs) viol++;
        prev_s = sclk;
        prev_cs = cs;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        rises = 0; hi_len = 0; lo_len = 0; bad_hi = 0; bad_lo = 0; viol = 0;
        rxv_cnt = 0; done_cnt = 0; cs_falls = 0; cs_rises = 0;
        cs_fall_cyc = -1; rxv_cyc = -1; done_cyc = -1;
        mbits = 0; fall_pend = 1'b0; mcap = 8'h00;
        mosi_q.delete(); rx_q.delete(); rise_q.delete();
    endtask

    task automatic start_byte(input logic [7:0] d, input logic l,
                              output int c);
        start = 1'b1; tx_data = d; last = l; c = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        for (int i = 0; i < maxc; i++) begin
            if (done_cnt != 0) break;
            tick();
        end
        chk("done_seen", 32'(done_cnt != 0), 32'd1);
    endtask

    task automatic wait_rises(input int n);
        for (int i = 0; i < 400; i++) begin
            if (rises >= n) break;
            tick();
        end
        chk("rises_reached", 32'(rises), 32'(n));
    endtask

    task automatic run_single(input logic [7:0] d, input logic [7:0] exp_rx);
        int c;
        clear_mon();
        start_byte(d, 1'b1, c);
        wait_done(300);
        chk("cs_fall_lat", 32'(cs_fall_cyc - c), 32'd1);
        chk("rxv_lat", 32'(rxv_cyc - c), 32'(SU + 16 * DIV + 1));
        chk("done_lat", 32'(done_cyc - c), 32'(SU + 16 * DIV + 1 + HO));
        chk("sclk_pulses", 32'(rises), 32'd8);
        chk("sclk_high_len", 32'(bad_hi), 32'd0);
        chk("sclk_low_len", 32'(bad_lo), 32'd0);
        chk("sclk_while_cs_high", 32'(viol), 32'd0);
        chk("rxv_count", 32'(rxv_cnt), 32'd1);
        chk("done_count", 32'(done_cnt), 32'd1);
        chk("rx_byte", 32'(rx_q.size() > 0 ? rx_q[0] : 8'hxx), 32'(exp_rx));
        chk("mosi_byte", 32'(mosi_q.size() > 0 ? mosi_q[0] : 8'hxx), 32'(d));
        chk("ready_after", 32'(ready), 32'd1);
    endtask

    task automatic run_burst(input logic [7:0] b [3], input int n);
        int c, g1;
        g1 = -1;
        clear_mon();
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin
                for (int i = 0; i < 300; i++) begin
                    if (ready && busy) break;
                    tick();
                end
                chk("gap_ready", 32'(ready && busy), 32'd1);
            end
            start_byte(b[k], k == n - 1, c);
            if (k == 1) g1 = c;
        end
        wait_done(300 * n);
        chk("burst_pulses", 32'(rises), 32'(8 * n));
        chk("burst_cs_falls", 32'(cs_falls), 32'd1);
        chk("burst_cs_rises", 32'(cs_rises), 32'd1);
        chk("burst_done", 32'(done_cnt), 32'd1);
        chk("burst_rxv", 32'(rxv_cnt), 32'(n));
        chk("burst_high_len", 32'(bad_hi), 32'd0);
        chk("burst_low_len", 32'(bad_lo), 32'd0);
        chk("burst_next_rise", 32'(rise_q.size() > 8 ? rise_q[8] - g1 : -1),
            32'(DIV + 1));
        for (int k = 0; k < n; k++) begin
            chk("burst_rx", 32'(rx_q.size() > k ? rx_q[k] : 8'hxx),
                32'(slave_byte));
            chk("burst_mosi", 32'(mosi_q.size() > k ? mosi_q[k] : 8'hxx),
                32'(b[k]));
        end
    endtask

    task automatic run_fast(input logic [7:0] d, input logic mi);
        int rxv_k, done_k, sbad;
        rxv_k = -1; done_k = -1; sbad = 0;
        miso_b = mi;
        start_b = 1'b1; tx_b = d; last_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("fast_cs_low", 32'(cs_b), 32'd0);
        for (int k = 1; k <= 24; k++) begin
            if (k >= 2 && k <= 17 && sclk_b !== 1'(k % 2)) sbad++;
            if (rx_valid_b && rxv_k < 0) rxv_k = k;
            if (done_b && done_k < 0) done_k = k;
            tick();
        end
        chk("fast_sclk_toggle", 32'(sbad), 32'd0);
        chk("fast_rxv_lat", 32'(rxv_k), 32'd18);
        chk("fast_done_lat", 32'(done_k), 32'd19);
        chk("fast_rx", 32'(rx_data_b), {32{mi}} & 32'hFF);
    endtask

    initial begin
        logic [7:0] d, e;
        logic [7:0] bb [3];
        int c;
        clr = 1'b1; start = 1'b0; last = 1'b0; abort = 1'b0; tx_data = 8'h00;
        start_b = 1'b0; last_b = 1'b0; abort_b = 1'b0; tx_b = 8'h00;
        miso_b = 1'b0;
        clear_mon();
        repeat (3) tick();
        chk("rst_cs", 32'(cs), 32'd1);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fast_cs", 32'(cs_b), 32'd1);
        clr = 1'b0;
        tick();

        loop_en = 1'b1;
        run_single(8'hA5, 8'hA5);
        repeat (3) begin
            d = 8'($urandom);
            run_single(d, d);
        end

        loop_en = 1'b0;
        slave_byte = 8'h3C;
        bb[0] = 8'h12; bb[1] = 8'h34; bb[2] = 8'h00;
        run_burst(bb, 2);
        slave_byte = 8'($urandom);
        bb[0] = 8'($urandom); bb[1] = 8'($urandom); bb[2] = 8'($urandom);
        run_burst(bb, 3);

        loop_en = 1'b1;
        clear_mon();
        d = 8'($urandom);
        start_byte(d, 1'b1, c);
        wait_rises(3);
        chk("ignored_start_ready", 32'(ready), 32'd0);
        start = 1'b1; tx_data = ~d; last = 1'b0;
        tick();
        start = 1'b0;
        wait_done(300);
        repeat (10) tick();
        chk("ignored_pulses", 32'(rises), 32'd8);
        chk("ignored_mosi", 32'(mosi_q.size() > 0 ? mosi_q[0] : 8'hxx),
            32'(d));
        chk("ignored_rx", 32'(rx_q.size() > 0 ? rx_q[0] : 8'hxx), 32'(d));
        chk("ignored_done", 32'(done_cnt), 32'd1);
        chk("ignored_idle", 32'(busy), 32'd0);

        clear_mon();
        start_byte(8'hFF, 1'b1, c);
        wait_rises(5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_cs", 32'(cs), 32'd1);
        chk("abort_sclk", 32'(sclk), 32'd0);
        chk("abort_mosi", 32'(mosi), 32'd0);
        chk("abort_ready", 32'(ready), 32'd1);
        repeat (80) tick();
        chk("abort_no_rxv", 32'(rxv_cnt), 32'd0);
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        chk("abort_rx_kept", 32'(rx_data), 32'(d));
        chk("abort_stays_idle", 32'(cs), 32'd1);
        e = 8'($urandom_range(1, 255));
        run_single(e, e);

        clear_mon();
        start_byte(8'($urandom), 1'b1, c);
        wait_rises(3);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_cs", 32'(cs), 32'd1);
        chk("clr_sclk", 32'(sclk), 32'd0);
        chk("clr_mosi", 32'(mosi), 32'd0);
        chk("clr_ready", 32'(ready), 32'd1);
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_rx_data", 32'(rx_data), 32'd0);
        chk("clr_rx_valid", 32'(rx_valid), 32'd0);
        clear_mon();
        start = 1'b1; abort = 1'b1; tx_data = 8'($urandom); last = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("start_abort_cs", 32'(cs), 32'd1);
        chk("start_abort_ready", 32'(ready), 32'd1);
        repeat (6) tick();
        chk("start_abort_idle", 32'(cs_falls), 32'd0);

        run_fast(8'hFF, 1'b0);
        run_fast(8'h00, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
